// File: rtl/twi_cmd_seq_pkg.sv
// Shared TWI definitions: engine command codes, sequencer states and the
// command payload carried towards the byte/bit engine.
package twi_cmd_seq_pkg;

  localparam int unsigned NUM_CMD    = 3;
  localparam int unsigned SIZE_SEQ   = 3;
  localparam int unsigned TWI_ADDR_W = 7;
  localparam int unsigned TWI_BYTE_W = 8;

  typedef enum logic [NUM_CMD-1:0] {
    CMD_START = 3'd0,
    CMD_WR    = 3'd1,
    CMD_RD    = 3'd2,
    CMD_STOP  = 3'd3
  } CMD_e;

  typedef enum logic [SIZE_SEQ-1:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_ADDR  = 3'd2,
    SEQ_WDATA = 3'd3,
    SEQ_RDATA = 3'd4,
    SEQ_STOP  = 3'd5
  } SEQ_e;

  typedef struct packed {
    CMD_e                  code;
    logic [TWI_BYTE_W-1:0] data;
    logic                  last;
  } twi_cmd_t;

  // Address byte as it goes on the wire: 7-bit address followed by R/W.
  function automatic logic [TWI_BYTE_W-1:0] addr_byte(input logic [TWI_ADDR_W-1:0] addr,
                                                      input logic                  rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/twi_cmd_seq.sv
// Transaction sequencer: turns one address/R-W/length request into the
// START / address / data / STOP command stream of the TWI byte engine.
module twi_cmd_seq
  import twi_cmd_seq_pkg::*;
#(
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [TWI_ADDR_W-1:0] req_addr,
  input  logic                  req_rw,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [NUM_CMD-1:0]    cmd_code,
  output logic [DATA_W-1:0]     cmd_data,
  output logic                  cmd_last,
  input  logic                  rsp_valid,
  input  logic                  rsp_ack,
  input  logic [DATA_W-1:0]     rsp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  nack_err
);

  SEQ_e                  state_q, state_d;
  logic                  issue_q, issue_d;
  logic [TWI_ADDR_W-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic                  nack_q, nack_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic                  done_q, done_d;
  logic                  nack_err_q, nack_err_d;

  twi_cmd_t              cmd_s;
  logic                  cmd_fire;
  logic                  rsp_fire;
  logic                  last_byte;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      issue_q    <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      count_q    <= '0;
      nack_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      nack_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      count_q    <= count_d;
      nack_q     <= nack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      nack_err_q <= nack_err_d;
    end
  end

  assign cmd_fire  = cmd_valid & cmd_ready;
  // Responses only count in the WAIT phase of a command state.
  assign rsp_fire  = rsp_valid & ~issue_q & (state_q != SEQ_IDLE);
  assign last_byte = (count_q <= LEN_W'(1));

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    issue_d    = issue_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    count_d    = count_q;
    nack_d     = nack_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    nack_err_d = 1'b0;

    if ((state_q != SEQ_IDLE) && issue_q && cmd_fire) begin
      issue_d = 1'b0;
    end

    case (state_q)
      SEQ_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          rw_d    = req_rw;
          count_d = req_len;
          nack_d  = 1'b0;
          issue_d = 1'b1;
          state_d = SEQ_START;
        end
      end
      SEQ_START: begin
        if (rsp_fire) begin
          issue_d = 1'b1;
          state_d = SEQ_ADDR;
        end
      end
      SEQ_ADDR: begin
        if (rsp_fire) begin
          issue_d = 1'b1;
          if (!rsp_ack) begin
            nack_d  = 1'b1;
            state_d = SEQ_STOP;
          end else if (count_q == '0) begin
            state_d = SEQ_STOP;
          end else if (rw_q) begin
            state_d = SEQ_RDATA;
          end else begin
            state_d = SEQ_WDATA;
          end
        end
      end
      SEQ_WDATA: begin
        if (rsp_fire) begin
          issue_d = 1'b1;
          if (count_q != '0) count_d = count_q - LEN_W'(1);
          if (!rsp_ack) begin
            nack_d  = 1'b1;
            state_d = SEQ_STOP;
          end else if (last_byte) begin
            state_d = SEQ_STOP;
          end
        end
      end
      SEQ_RDATA: begin
        if (rsp_fire) begin
          issue_d    = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = rsp_data;
          if (count_q != '0) count_d = count_q - LEN_W'(1);
          if (last_byte) state_d = SEQ_STOP;
        end
      end
      SEQ_STOP: begin
        if (rsp_fire) begin
          done_d     = 1'b1;
          nack_err_d = nack_q;
          issue_d    = 1'b0;
          state_d    = SEQ_IDLE;
        end
      end
      default: begin
        issue_d = 1'b0;
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // Output decode; write bytes pass straight through to the engine.
  always_comb begin
    cmd_s      = '{code: CMD_START, data: '0, last: 1'b0};
    cmd_valid  = 1'b0;
    wr_ready   = 1'b0;
    req_ready  = (state_q == SEQ_IDLE);
    busy       = (state_q != SEQ_IDLE);

    case (state_q)
      SEQ_START: begin
        cmd_valid = issue_q;
      end
      SEQ_ADDR: begin
        cmd_valid  = issue_q;
        cmd_s.code = CMD_WR;
        cmd_s.data = addr_byte(addr_q, rw_q);
      end
      SEQ_WDATA: begin
        cmd_valid  = issue_q & wr_valid;
        cmd_s.code = CMD_WR;
        cmd_s.data = TWI_BYTE_W'(wr_data);
        wr_ready   = issue_q & cmd_ready;
      end
      SEQ_RDATA: begin
        cmd_valid  = issue_q;
        cmd_s.code = CMD_RD;
        cmd_s.last = (count_q == LEN_W'(1));
      end
      SEQ_STOP: begin
        cmd_valid  = issue_q;
        cmd_s.code = CMD_STOP;
      end
      default: begin
        cmd_valid = 1'b0;
      end
    endcase
  end

  assign cmd_code = cmd_s.code;
  assign cmd_data = DATA_W'(cmd_s.data);
  assign cmd_last = cmd_s.last;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign nack_err = nack_err_q;

endmodule

// File: tb/tb_twi_cmd_seq.sv
// Self-checking bench for twi_cmd_seq: a behavioural engine/host model drives
// transactions and the expected command stream is derived per transaction.
module tb_twi_cmd_seq;
  import twi_cmd_seq_pkg::*;

  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_rw = 1'b0;
  logic [6:0]       req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             cmd_ready = 1'b0;
  logic             rsp_valid = 1'b0;
  logic             rsp_ack = 1'b0;
  logic [7:0]       rsp_data = '0;
  logic             req_ready, wr_ready, rd_valid, cmd_valid, cmd_last, busy, done, nack_err;
  logic [7:0]       rd_data, cmd_data;
  logic [2:0]       cmd_code;

  always #5 clk = ~clk;

  twi_cmd_seq #(.LEN_W(LEN_W), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_data(cmd_data), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .busy(busy), .done(done), .nack_err(nack_err)
  );

  typedef struct packed {
    logic [2:0] code;
    logic [7:0] data;
    logic       last;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  int         txn_id = 0;
  ev_t        exp_cmd[$];
  ev_t        got_cmd[$];
  logic [7:0] wr_q[$];
  logic [7:0] rd_src[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];
  logic [7:0] dir_bytes[$];

  // Engine / host behaviour knobs
  int  ready_pct = 100;
  int  rsp_max_dly = 0;
  int  wr_stall_pct = 0;
  int  spur_pct = 0;
  bit  poke_req = 1'b0;
  int  ready_low_budget = 0;
  int  wr_low_budget = 0;
  int  nack_at = -1;

  bit         req_pend = 1'b0;
  bit         pending = 1'b0;
  bit         wr_hold = 1'b0;
  bit         acc_flag = 1'b0;
  int         dly = 0;
  int         wr_idx = 0;
  int         wr_taken = 0;
  int         done_cnt = 0;
  int         accepts = 0;
  logic       pend_ack = 1'b1;
  logic       done_nack = 1'b0;
  logic [7:0] pend_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn_id, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic [2:0] c, input logic [7:0] d, input logic l);
    ev_t e;
    e = {c, d, l};
    return e;
  endfunction

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_code", 32'(cmd_code), 32'(CMD_START));
    check("rst_cmd_data", 32'(cmd_data), 0);
    check("rst_cmd_last", 32'(cmd_last), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_nack_err", 32'(nack_err), 0);
  endtask

  // One clock cycle: drive at negedge, let comb settle, observe the handshakes
  // that the following posedge will commit.
  task automatic step();
    ev_t cur;
    int  nxt;
    @(negedge clk);
    req_valid = req_pend || (poke_req && busy && ($urandom_range(3) == 0));
    if (pending && dly == 0) begin
      rsp_valid = 1'b1;
      rsp_ack   = pend_ack;
      rsp_data  = pend_data;
    end else begin
      if (pending) dly--;
      rsp_valid = !pending && (int'($urandom_range(99)) < spur_pct);
      rsp_ack   = 1'($urandom);
      rsp_data  = 8'($urandom);
    end
    if (!wr_hold) begin
      if (wr_q.size() > 0 && wr_low_budget > 0 && wr_taken > 0) begin
        wr_valid = 1'b0;
        wr_low_budget--;
      end else if (wr_q.size() > 0 && int'($urandom_range(99)) >= wr_stall_pct) begin
        wr_valid = 1'b1;
        wr_data  = wr_q[0];
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
      end
    end
    #1;
    if (ready_low_budget > 0 && cmd_valid && cmd_code == 3'(CMD_WR) && wr_idx > 0) begin
      cmd_ready = 1'b0;
      ready_low_budget--;
    end else begin
      cmd_ready = (int'($urandom_range(99)) < ready_pct);
    end
    #1;
    cur = {cmd_code, cmd_data, cmd_last};
    if (acc_flag) begin
      check("start_valid", 32'(cmd_valid), 1);
      check("start_code", 32'(cmd_code), 32'(CMD_START));
      acc_flag = 1'b0;
    end
    // A stalled offer must already be the next command the model expects.
    if (cmd_valid && !cmd_ready) begin
      nxt = got_cmd.size();
      if (nxt < exp_cmd.size()) begin
        check("held_code", 32'(cmd_code), 32'(exp_cmd[nxt].code));
        if (exp_cmd[nxt].code == 3'(CMD_WR)) check("held_data", 32'(cmd_data), 32'(exp_cmd[nxt].data));
        if (exp_cmd[nxt].code == 3'(CMD_RD)) check("held_last", 32'(cmd_last), 32'(exp_cmd[nxt].last));
      end else begin
        check("extra_offer", 32'(nxt), 32'(exp_cmd.size() - 1));
      end
    end
    if (rsp_valid) pending = 1'b0;
    if (cmd_valid && cmd_ready) begin
      got_cmd.push_back(cur);
      pending   = 1'b1;
      dly       = int'($urandom_range(32'(rsp_max_dly)));
      pend_ack  = 1'b1;
      pend_data = 8'($urandom);
      if (cmd_code == 3'(CMD_START)) wr_idx = 0;
      if (cmd_code == 3'(CMD_WR)) begin
        pend_ack = (wr_idx != nack_at);
        wr_idx++;
      end
      if (cmd_code == 3'(CMD_RD) && rd_src.size() > 0) pend_data = rd_src.pop_front();
    end
    wr_hold = wr_valid && !wr_ready;
    if (wr_valid && wr_ready) begin
      void'(wr_q.pop_front());
      wr_taken++;
    end
    if (rd_valid) got_rd.push_back(rd_data);
    if (done) begin
      done_cnt++;
      done_nack = nack_err;
    end
    if (req_valid && busy) check("req_ready_busy", 32'(req_ready), 0);
    if (req_valid && req_ready) begin
      accepts++;
      req_pend = 1'b0;
      acc_flag = 1'b1;
    end
  endtask

  // Build the expected stream from the protocol rules, run, then compare.
  // nk: index of the WR command the engine NACKs (0 = address, -1 = none).
  task automatic run_txn(input logic [6:0] a, input logic rw, input int len, input int nk);
    logic [7:0] b;
    bit         exp_nack;
    int         exp_wr;
    int         cyc;
    txn_id++;
    wr_q.delete(); rd_src.delete(); exp_cmd.delete(); got_cmd.delete();
    exp_rd.delete(); got_rd.delete();
    for (int i = 0; i < len; i++) begin
      b = (dir_bytes.size() == len) ? dir_bytes[i] : 8'($urandom);
      if (rw) rd_src.push_back(b);
      else    wr_q.push_back(b);
    end
    dir_bytes.delete();
    exp_cmd.push_back(mk(3'(CMD_START), 8'h00, 1'b0));
    exp_cmd.push_back(mk(3'(CMD_WR), {a, rw}, 1'b0));
    exp_nack = (nk == 0);
    exp_wr   = 0;
    if (!exp_nack) begin
      for (int i = 0; i < len; i++) begin
        if (rw) begin
          exp_cmd.push_back(mk(3'(CMD_RD), 8'h00, (i == len - 1)));
          exp_rd.push_back(rd_src[i]);
        end else begin
          exp_cmd.push_back(mk(3'(CMD_WR), wr_q[i], 1'b0));
          exp_wr++;
          if (nk == i + 1) begin
            exp_nack = 1'b1;
            break;
          end
        end
      end
    end
    exp_cmd.push_back(mk(3'(CMD_STOP), 8'h00, 1'b0));

    nack_at = nk; wr_hold = 1'b0; wr_valid = 1'b0; pending = 1'b0;
    wr_taken = 0; done_cnt = 0; accepts = 0; wr_idx = 0; acc_flag = 1'b0;
    req_addr = a; req_rw = rw; req_len = LEN_W'(len); req_pend = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      step();
      cyc++;
    end
    req_pend = 1'b0;
    repeat (3) step();

    check("done_count", 32'(done_cnt), 1);
    check("accepts", 32'(accepts), 1);
    check("nack_err", 32'(done_nack), 32'(exp_nack));
    check("wr_consumed", 32'(wr_taken), 32'(exp_wr));
    check("cmd_count", 32'(got_cmd.size()), 32'(exp_cmd.size()));
    for (int i = 0; i < got_cmd.size() && i < exp_cmd.size(); i++) begin
      check("cmd_code", 32'(got_cmd[i].code), 32'(exp_cmd[i].code));
      if (exp_cmd[i].code == 3'(CMD_WR)) check("cmd_data", 32'(got_cmd[i].data), 32'(exp_cmd[i].data));
      if (exp_cmd[i].code == 3'(CMD_RD)) check("cmd_last", 32'(got_cmd[i].last), 32'(exp_cmd[i].last));
    end
    check("rd_count", 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++) begin
      check("rd_byte", 32'(got_rd[i]), 32'(exp_rd[i]));
    end
    check("idle_req_ready", 32'(req_ready), 1);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int cyc;
    int len_r;
    int nk_r;

    repeat (2) step();
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: write, read, address NACK, probe
    dir_bytes = '{8'h11, 8'h22};
    run_txn(7'h50, 1'b0, 2, -1);
    dir_bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_txn(7'h50, 1'b1, 3, -1);
    run_txn(7'h3C, 1'b0, 4, 0);
    run_txn(7'h68, 1'b0, 0, -1);

    // Backpressure on data writes, write-source gaps, requests while busy
    ready_low_budget = 5;
    wr_low_budget    = 3;
    poke_req         = 1'b1;
    run_txn(7'h2A, 1'b0, 6, -1);
    run_txn(7'h21, 1'b0, 5, 3);
    poke_req         = 1'b0;

    // Reset in the middle of a read
    txn_id++;
    got_cmd.delete(); exp_cmd.delete(); rd_src.delete();
    for (int i = 0; i < 5; i++) rd_src.push_back(8'($urandom));
    nack_at = -1; pending = 1'b0; wr_idx = 0;
    req_addr = 7'h44; req_rw = 1'b1; req_len = LEN_W'(5); req_pend = 1'b1;
    cyc = 0;
    while (got_cmd.size() < 3 && cyc < 200) begin
      step();
      cyc++;
    end
    check("reached_rdata", 32'(got_cmd.size()), 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    req_pend = 1'b0; pending = 1'b0; acc_flag = 1'b0;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(7'h55, 1'b1, 2, -1);

    // Randomized traffic with ready/response jitter and spurious responses
    ready_pct = 70; rsp_max_dly = 3; wr_stall_pct = 30; spur_pct = 15; poke_req = 1'b1;
    for (int t = 0; t < 25; t++) begin
      len_r = int'($urandom_range(7));
      nk_r  = ($urandom_range(3) == 0) ? int'($urandom_range(32'(len_r))) : -1;
      run_txn(7'($urandom), 1'($urandom), len_r, nk_r);
    end

    // Maximum length read: counter must reach zero exactly once
    ready_pct = 100; rsp_max_dly = 0; wr_stall_pct = 0; spur_pct = 0; poke_req = 1'b0;
    run_txn(7'h7F, 1'b1, 255, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twi_cmd_seq.md
Name: twi_cmd_seq

Overview:
Transaction sequencer that sits directly upstream of the TWI byte/bit engine.
- Accepts one transaction request: 7-bit slave address, R/W, byte length.
- Breaks it into the engine's command stream: CMD_START, CMD_WR (address byte), CMD_WR/CMD_RD per data byte, CMD_STOP.
- Routes write bytes from a data stream into the engine and returns read bytes and completion/NACK status to the register/host side.

Parameters:
LEN_W, 8, width of transaction byte count (max LEN = 2^LEN_W-1)
DATA_W, 8, byte width; fixed at 8 (TWI byte)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  transaction request valid
req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready
req_addr  in  7  slave address
req_rw  in  1  0=write, 1=read
req_len  in  LEN_W  data byte count; 0 = address-only probe
wr_valid  in  1  write byte available
wr_ready  out  1  write byte consumed
wr_data  in  8  write byte
rd_valid  out  1  one-cycle pulse, read byte valid (no backpressure)
rd_data  out  8  read byte
cmd_valid  out  1  command to engine valid
cmd_ready  in  1  engine accepts command
cmd_code  out  3  CMD_e value (NUM_CMD bits)
cmd_data  out  8  byte for CMD_WR
cmd_last  out  1  on CMD_RD: last byte, engine sends NACK
rsp_valid  in  1  engine finished the accepted command (one pulse per command)
rsp_ack  in  1  slave ACK for CMD_WR (valid with rsp_valid)
rsp_data  in  8  received byte for CMD_RD (valid with rsp_valid)
busy  out  1  transaction in progress
done  out  1  one-cycle pulse after STOP response
nack_err  out  1  valid with done; transaction saw a NACK

Behaviour:
- Reset values: req_ready=1, busy=0, cmd_valid=0, cmd_code=CMD_START, cmd_data=0, cmd_last=0, wr_ready=0, rd_valid=0, rd_data=0, done=0, nack_err=0. State SEQ_IDLE, count=0, nack flag=0.
- Exactly one command outstanding. Each command state has an ISSUE phase (cmd_valid=1, cmd_code/cmd_data/cmd_last held stable until cmd_ready) and a WAIT phase (cmd_valid=0 until rsp_valid). rsp_valid in ISSUE phase or IDLE is ignored.
- States and transitions:
  - SEQ_IDLE: on req accept, latch addr/rw/len, clear nack flag, busy=1, go SEQ_START. Request accepted in cycle N gives cmd_valid with CMD_START in cycle N+1.
  - SEQ_START: CMD_START; on rsp go SEQ_ADDR.
  - SEQ_ADDR: CMD_WR, cmd_data={addr,rw}. On rsp:
    - rsp_ack=0: set nack, go SEQ_STOP.
    - len=0: go SEQ_STOP.
    - rw=0: go SEQ_WDATA.
    - rw=1: go SEQ_RDATA.
  - SEQ_WDATA: cmd_valid=wr_valid; cmd_data=wr_data; wr_ready=cmd_ready (combinational pass-through in ISSUE phase only). On rsp, count decrements.
    - rsp_ack=0: set nack, go SEQ_STOP; remaining write bytes are not consumed.
    - count reaches 0: go SEQ_STOP.
  - SEQ_RDATA: CMD_RD, cmd_last=(count==1). On rsp, rd_valid=1 and rd_data=rsp_data in the next cycle; count decrements; count reaches 0 goes SEQ_STOP.
  - SEQ_STOP: CMD_STOP. On rsp, done=1 and nack_err=nack for one cycle, busy=0, req_ready=1, go SEQ_IDLE.
- req_ready=0 whenever busy; requests presented while busy are not accepted.
- Counter: LEN_W bits, loaded with req_len, never wraps; it is only decremented when nonzero.
- wr_valid low during SEQ_WDATA: cmd_valid stays low and the sequencer waits indefinitely (no timeout).
- Reset mid-operation: everything returns to reset values immediately. No STOP is issued; engine reset is the engine's responsibility.

Decomposition:
- Add to the shared TWI package:
  - enum SEQ_e {SEQ_IDLE, SEQ_START, SEQ_ADDR, SEQ_WDATA, SEQ_RDATA, SEQ_STOP} with size constant SIZE_SEQ=3.
  - TWI_ADDR_W=7.
  - TWI_BYTE_W=8.
- Reuse the existing CMD_e for cmd_code.
- Single module; no sub-module warranted.

Test Plan:
- Write addr 0x50, len 2, data 0x11,0x22, engine always ready/ACK -> commands START, WR 0xA0, WR 0x11, WR 0x22, STOP; done=1, nack_err=0; wr_ready pulses twice.
- Read addr 0x50, len 3, rsp_data 0xAA,0xBB,0xCC -> START, WR 0xA1, RD(last=0), RD(last=0), RD(last=1), STOP; rd_valid three pulses with 0xAA,0xBB,0xCC in order.
- Write addr 0x3C len 4, rsp_ack=0 on address -> next command STOP, wr_ready never asserted, done=1 with nack_err=1.
- Probe addr 0x68 len 0 -> START, WR 0xD0, STOP; no data commands; done=1.
- Backpressure: cmd_ready low 5 cycles during WR data; wr_valid low 3 cycles mid-write -> cmd_code/cmd_data stable while cmd_valid=1; no byte lost or duplicated; req_valid pulsed while busy is not accepted.
- Assert rst_n=0 during SEQ_RDATA -> all outputs at reset values in the same cycle; a new request after release starts with CMD_START.
